pc_gen: RTL

Parametrised fetch program-counter generator for the pipelined CPU. It holds the fetch PC and steps it sequentially each cycle. It accepts branch/jump redirects, exception entry and exception return (eret), and freezes on pipeline stall. A redirect that arrives while fetch is stalled is latched and applied when the stall releases, so no redirect is lost. It sits at the head of the IF stage, feeding the instruction memory address and the IF/ID register.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/pc_next_mux.sv | 49 ++++
 rtl/pc_gen.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception vectors and the fetch-PC state encoding.
package cpu_pkg;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_PEND = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select of next fetch PC, state and held redirect target.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(PC_EXC_VEC)
) (
    input  pc_state_t          state_q_i,
    input  logic [WIDTH-1:0]   pc_q_i,
    input  logic [WIDTH-1:0]   pc_plus_i,
    input  logic [WIDTH-1:0]   pend_q_i,
    input  logic               stall_i,
    input  logic               br_valid_i,
    input  logic [WIDTH-1:0]   br_target_i,
    input  logic               exc_valid_i,
    input  logic               eret_valid_i,
    input  logic [WIDTH-1:0]   epc_i,
    output logic [WIDTH-1:0]   pc_d_o,
    output pc_state_t          state_d_o,
    output logic [WIDTH-1:0]   pend_d_o
);

    always_comb begin
        pc_d_o    = pc_plus_i;
        state_d_o = state_q_i;
        pend_d_o  = pend_q_i;
        // exception beats eret, both beat stall and any held redirect
        if (exc_valid_i) begin
            pc_d_o    = EXC_VEC;
            state_d_o = PC_RUN;
        end else if (eret_valid_i) begin
            pc_d_o    = epc_i;
            state_d_o = PC_RUN;
        end else if (stall_i) begin
            pc_d_o = pc_q_i;
            if (br_valid_i) begin
                pend_d_o  = br_target_i;
                state_d_o = PC_PEND;
            end
        end else if (br_valid_i) begin
            pc_d_o    = br_target_i;
            state_d_o = PC_RUN;
        end else if (state_q_i == PC_PEND) begin
            pc_d_o    = pend_q_i;
            state_d_o = PC_RUN;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with stall-safe redirect holding.
// Optional macro PC_ALIGN_CHECK_EN adds a registered pc_misalign flag.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
    parameter int               STEP      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redir_pending,
    output logic             pc_misalign,
    output pc_state_t        dbg_state_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    pc_state_t        state_q, state_d;

    assign pc_plus = pc_q + WIDTH'(STEP);

    pc_next_mux #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC)
    ) u_mux (
        .state_q_i    (state_q),
        .pc_q_i       (pc_q),
        .pc_plus_i    (pc_plus),
        .pend_q_i     (pend_q),
        .stall_i      (stall),
        .br_valid_i   (br_valid),
        .br_target_i  (br_target),
        .exc_valid_i  (exc_valid),
        .eret_valid_i (eret_valid),
        .epc_i        (epc),
        .pc_d_o       (pc_d),
        .state_d_o    (state_d),
        .pend_d_o     (pend_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            state_q <= PC_RUN;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    // tracks whatever value pc loads, so every redirect source is covered
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= |RESET_VEC[1:0];
        end else begin
            misalign_q <= |pc_d[1:0];
        end
    end

    assign pc_misalign = misalign_q;
`else
    assign pc_misalign = 1'b0;
`endif

    assign pc            = pc_q;
    assign redir_pending = (state_q == PC_PEND);
    assign dbg_state_o   = state_q;

endmodule
